hmj_ld_cmd_tx: RTL and testbench

HMJ_LD_CMD_TX -- requirements
Module: hmj_ld_cmd_tx

---
 rtl/hmj_ld_cmd_tx.sv | 208 ++++++++++++++++++++
 tb/tb_hmj_ld_cmd_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hmj_ld_cmd_tx.sv
// hmj_ld_cmd_tx
// Builds one radar command frame from a captured command and streams it out
// as UART 8N1. Frame layout:
//   FD FC FB FA | LEN_L LEN_H | CMD_L CMD_H | payload[0..N-1] | 04 03 02 01
// where N = clamp(payload_len, 4) and LEN = 2 + N.
//
// Ports
//   i_sys_clk      system clock
//   i_sys_rst      asynchronous active-high reset
//   i_cmd_vld      command request, taken when o_cmd_rdy is high
//   o_cmd_rdy      idle and able to accept a command
//   i_cmd_word     16-bit command word
//   i_payload      32-bit command value, byte 0 = bits [7:0]
//   i_payload_len  payload byte count 0..4 (larger values clamp to 4)
//   o_uart_txd     registered serial line, idle high
//   o_busy         frame transmission in progress
//   o_done         one-cycle pulse after the last stop bit
module hmj_ld_cmd_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_cmd_vld,
    output logic        o_cmd_rdy,
    input  logic [15:0] i_cmd_word,
    input  logic [31:0] i_payload,
    input  logic [2:0]  i_payload_len,
    output logic        o_uart_txd,
    output logic        o_busy,
    output logic        o_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [3:0]       byte_idx_reg, byte_idx_next;
    logic [15:0]      cmd_reg;
    logic [31:0]      payload_reg;
    logic [2:0]       len_reg;
    logic             arm_reg;
    logic             txd_reg, txd_next;

    logic             accept;
    logic [3:0]       len4;
    logic [3:0]       last_idx;
    logic [3:0]       tail_idx;
    logic [7:0]       tx_byte;
    logic [7:0]       pay_byte [4];

    // Ready only in IDLE once out of reset; the DONE cycle is excluded so a
    // new command always lands at least one cycle after o_done.
    assign o_cmd_rdy  = arm_reg && (state_reg == S_IDLE);
    assign accept     = i_cmd_vld && o_cmd_rdy;
    assign o_uart_txd = txd_reg;

    assign len4     = {1'b0, len_reg};
    assign last_idx = 4'd11 + len4;
    assign tail_idx = byte_idx_reg - 4'd8 - len4;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pay
            assign pay_byte[gi] = payload_reg[8*gi +: 8];
        end
    endgenerate

    // Byte currently on the line, built only from captured registers.
    // Payload offset (idx - 8) reduces to idx[1:0] because 8 is a multiple of 4.
    always_comb begin
        tx_byte = 8'h01;
        if (byte_idx_reg < 4'd4) begin
            case (byte_idx_reg[1:0])
                2'd0:    tx_byte = 8'hFD;
                2'd1:    tx_byte = 8'hFC;
                2'd2:    tx_byte = 8'hFB;
                default: tx_byte = 8'hFA;
            endcase
        end else if (byte_idx_reg == 4'd4) begin
            tx_byte = {5'd0, len_reg} + 8'd2;
        end else if (byte_idx_reg == 4'd5) begin
            tx_byte = 8'h00;
        end else if (byte_idx_reg == 4'd6) begin
            tx_byte = cmd_reg[7:0];
        end else if (byte_idx_reg == 4'd7) begin
            tx_byte = cmd_reg[15:8];
        end else if (byte_idx_reg < (4'd8 + len4)) begin
            tx_byte = pay_byte[byte_idx_reg[1:0]];
        end else begin
            case (tail_idx[1:0])
                2'd0:    tx_byte = 8'h04;
                2'd1:    tx_byte = 8'h03;
                2'd2:    tx_byte = 8'h02;
                default: tx_byte = 8'h01;
            endcase
        end
    end

    // State register, counters and command capture.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state_reg    <= S_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            cmd_reg      <= '0;
            payload_reg  <= '0;
            len_reg      <= '0;
            arm_reg      <= 1'b0;
            txd_reg      <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
            arm_reg      <= 1'b1;
            txd_reg      <= txd_next;
            if (accept) begin
                cmd_reg     <= i_cmd_word;
                payload_reg <= i_payload;
                len_reg     <= (i_payload_len > 3'd4) ? 3'd4 : i_payload_len;
            end
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;
        case (state_reg)
            S_IDLE: begin
                baud_cnt_next = '0;
                bit_idx_next  = '0;
                byte_idx_next = '0;
                if (accept) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (baud_cnt_reg == CNT_LAST) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = S_DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_cnt_reg == CNT_LAST) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_cnt_reg == CNT_LAST) begin
                    baud_cnt_next = '0;
                    if (byte_idx_reg == last_idx) begin
                        state_next = S_DONE;
                    end else begin
                        byte_idx_next = byte_idx_reg + 4'd1;
                        state_next    = S_START;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                byte_idx_next = '0;
                state_next    = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs. The line level is computed from the next state so the txd
    // register lines up with the state register.
    always_comb begin
        o_busy   = (state_reg == S_START) || (state_reg == S_DATA) || (state_reg == S_STOP);
        o_done   = (state_reg == S_DONE);
        txd_next = 1'b1;
        case (state_next)
            S_START: txd_next = 1'b0;
            S_DATA:  txd_next = tx_byte[bit_idx_next];
            default: txd_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_hmj_ld_cmd_tx.sv
module tb_hmj_ld_cmd_tx;

    // 1_000_000 / 58_000 = 17.24 -> 17 clocks per bit (truncation)
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 58_000;
    localparam int DIV      = 17;
    localparam int BYTE_CYC = 10 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [15:0] cmd_word = '0;
    logic [31:0] payload = '0;
    logic [2:0]  payload_len = '0;
    logic        uart_txd;
    logic        busy;
    logic        done;

    hmj_ld_cmd_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .i_sys_clk    (clk),
        .i_sys_rst    (rst),
        .i_cmd_vld    (cmd_vld),
        .o_cmd_rdy    (cmd_rdy),
        .i_cmd_word   (cmd_word),
        .i_payload    (payload),
        .i_payload_len(payload_len),
        .o_uart_txd   (uart_txd),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int         exp_done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART receiver: decodes each byte, checks framing, bit stability over
    // every bit period and the byte value against the scoreboard.
    logic [9:0] mid_bits;
    logic [7:0] rx_byte;
    logic [7:0] exp_byte;
    logic       first_s;
    int         unstable;
    bit         abort;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && uart_txd == 1'b0) begin
                abort    = 1'b0;
                unstable = 0;
                mid_bits = '0;
                first_s  = 1'b0;
                for (int k = 0; k < 10 && !abort; k++) begin
                    for (int s = 0; s < DIV && !abort; s++) begin
                        if (!(k == 0 && s == 0)) @(negedge clk);
                        if (rst) begin
                            abort = 1'b1;
                        end else begin
                            if (s == 0) first_s = uart_txd;
                            else if (uart_txd !== first_s) unstable++;
                            if (s == DIV / 2) mid_bits[k] = uart_txd;
                        end
                    end
                end
                if (!abort) begin
                    rx_byte = mid_bits[8:1];
                    check("start_bit", {31'd0, mid_bits[0]}, 32'd0);
                    check("stop_bit", {31'd0, mid_bits[9]}, 32'd1);
                    check("bit_timing_unstable", unstable, 0);
                    check("byte_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                    if (exp_q.size() > 0) begin
                        exp_byte = exp_q.pop_front();
                        check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_byte});
                    end
                end
            end
        end
    end

    // Done monitor: each o_done must match the next expected completion cycle.
    int exp_done;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                check("done_expected", {31'd0, exp_done_q.size() > 0}, 32'd1);
                if (exp_done_q.size() > 0) begin
                    exp_done = exp_done_q.pop_front();
                    check("done_cycle", cyc, exp_done);
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                    $display("done at cycle %0d (expected %0d)", cyc, exp_done);
                end
            end
        end
    end

    // Issue one command; expected bytes are given MSB-first in bytes_v.
    task automatic send_cmd(input logic [15:0] w, input logic [31:0] p, input logic [2:0] n,
                            input int nbytes, input logic [127:0] bytes_v);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!cmd_rdy && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check("rdy_wait", {31'd0, cmd_rdy}, 32'd1);
        for (int i = 0; i < nbytes; i++) exp_q.push_back(bytes_v[8*(nbytes-1-i) +: 8]);
        exp_done_q.push_back(cyc + 1 + nbytes * BYTE_CYC);
        cmd_vld     = 1'b1;
        cmd_word    = w;
        payload     = p;
        payload_len = n;
        $display("cmd %04h payload %08h len %0d -> %0d bytes", w, p, n, nbytes);
        @(negedge clk);
        cmd_vld     = 1'b0;
        cmd_word    = ~w;
        payload     = ~p;
        payload_len = 3'd1;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("txd_first_start", {31'd0, uart_txd}, 32'd0);
        check("rdy_while_busy", {31'd0, cmd_rdy}, 32'd0);
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (exp_done_q.size() != 0 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check("frame_complete", exp_done_q.size(), 0);
        check("bytes_consumed", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        #1;
        check("rdy_before_first_edge", {31'd0, cmd_rdy}, 32'd0);
        @(negedge clk);
        check("rdy_after_first_edge", {31'd0, cmd_rdy}, 32'd1);

        // Enable-config command
        send_cmd(16'h00FF, 32'h0000_0001, 3'd2, 14, 128'hFDFCFBFA_0400_FF00_0100_04030201);
        wait_idle();

        // Zero-payload command
        send_cmd(16'h0061, 32'h1234_5678, 3'd0, 12, 128'hFDFCFBFA_0200_6100_04030201);
        wait_idle();

        // Length 7 clamps to 4
        send_cmd(16'h1234, 32'hDDCC_BBAA, 3'd7, 16, 128'hFDFCFBFA_0600_3412_AABBCCDD_04030201);
        wait_idle();

        // Request pulsed during byte 5 must be ignored
        send_cmd(16'h0102, 32'h0000_0055, 3'd1, 13, 128'hFDFCFBFA_0300_0201_55_04030201);
        repeat (900) @(negedge clk);
        check("rdy_mid_frame", {31'd0, cmd_rdy}, 32'd0);
        cmd_vld     = 1'b1;
        cmd_word    = 16'hBEEF;
        payload     = 32'hCAFE_F00D;
        payload_len = 3'd3;
        @(negedge clk);
        cmd_vld = 1'b0;
        wait_idle();

        // Reset during DATA bit 0 of byte 3 (FA, bit 0 = 0)
        send_cmd(16'h00AA, 32'h0, 3'd0, 12, 128'hFDFCFBFA_0200_AA00_04030201);
        repeat (535) @(negedge clk);
        check("txd_before_abort", {31'd0, uart_txd}, 32'd0);
        rst = 1'b1;
        #1;
        check("abort_txd", {31'd0, uart_txd}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_done_q.delete();
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Full frame after the aborted one
        send_cmd(16'h00FF, 32'h0000_0001, 3'd2, 14, 128'hFDFCFBFA_0400_FF00_0100_04030201);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
